count_ctrl: RTL and testbench

Run/pause/clear controller for the 4-digit BCD up/down counter datapath. It debounces the raw pushbuttons, runs a four-state control FSM and a programmable prescaler, and drives the datapath with a one-cycle count strobe, a direction level and a synchronous clear. It sits between the board I/O (`btn_n`, `sw`) and the counter, which reports its terminal values back through `at_max` and `at_min`.

---
 rtl/count_ctrl_if.sv | 23 ++
 rtl/count_ctrl.sv | 162 ++++++++++++++++
 tb/tb_count_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_ctrl_if.sv
// Board/datapath-facing signal bundle for the run/pause/clear controller.
// The master side drives buttons, switches and terminal flags; the slave side is the controller.
interface count_ctrl_if;
    logic [2:0] btn_n;
    logic [2:0] sw;
    logic       at_max;
    logic       at_min;
    logic       tick;
    logic       dir;
    logic       clr;
    logic       running;
    logic       done;

    modport master (
        output btn_n, sw, at_max, at_min,
        input  tick, dir, clr, running, done
    );

    modport slave (
        input  btn_n, sw, at_max, at_min,
        output tick, dir, clr, running, done
    );
endinterface

// File: rtl/count_ctrl.sv
// Run/pause/clear controller for a 4-digit BCD up/down counter: button debounce,
// four-state control FSM and programmable prescaler producing count/clear strobes.
module count_ctrl #(
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    count_ctrl_if.slave  bus
);

    localparam int unsigned PS_W = $clog2(TICK_DIV);
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PS_W-1:0] LIM_NORM = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0] LIM_FAST = PS_W'(TICK_DIV / 2 - 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Input synchronizers (buttons idle high)
    logic [2:0] r_btn_s1, r_btn_s2;
    logic [2:0] r_sw_s1,  r_sw_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_s1 <= 3'b111;
            r_btn_s2 <= 3'b111;
            r_sw_s1  <= 3'b000;
            r_sw_s2  <= 3'b000;
        end else begin
            r_btn_s1 <= bus.btn_n;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= bus.sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Debounced levels are kept active-high (1 = pressed)
    logic [2:0]      w_lvl;
    logic [2:0]      r_deb;
    logic [2:0]      r_deb_q;
    logic [2:0]      r_press;
    logic [DB_W-1:0] r_db_cnt [3];

    assign w_lvl = ~r_btn_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb   <= 3'b000;
            r_deb_q <= 3'b000;
            r_press <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_deb_q <= r_deb;
            r_press <= r_deb & ~r_deb_q;
            for (int i = 0; i < 3; i++) begin
                if (w_lvl[i] != r_deb[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_deb[i]    <= w_lvl[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    logic w_start, w_clear, w_dirp;
    logic w_fast, w_oneshot, w_hold;

    assign w_start   = r_press[0];
    assign w_clear   = r_press[1];
    assign w_dirp    = r_press[2];
    assign w_fast    = r_sw_s2[0];
    assign w_oneshot = r_sw_s2[1];
    assign w_hold    = r_sw_s2[2];

    state_t          r_state;
    logic [PS_W-1:0] r_ps;
    logic            r_tick, r_dir, r_clr, r_running, r_done;

    logic [PS_W-1:0] w_limit;
    logic            w_count, w_wrap, w_term, w_stop;

    // ">=" lets a mid-count switch to fast mode wrap on the next counting cycle
    assign w_limit = w_fast ? LIM_FAST : LIM_NORM;
    assign w_count = (r_state == S_RUN) && !w_hold;
    assign w_wrap  = w_count && (r_ps >= w_limit);
    assign w_term  = r_dir ? bus.at_min : bus.at_max;
    assign w_stop  = w_wrap && w_oneshot && w_term;

    // Control FSM with prescaler and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ps      <= '0;
            r_tick    <= 1'b0;
            r_dir     <= 1'b0;
            r_clr     <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_clr  <= 1'b0;
            if (w_clear) begin
                r_clr     <= 1'b1;
                r_state   <= S_IDLE;
                r_ps      <= '0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                if (w_count) begin
                    r_ps <= w_wrap ? '0 : r_ps + PS_W'(1);
                end
                r_tick <= w_wrap && !w_stop;
                if (w_start) begin
                    case (r_state)
                        S_IDLE, S_PAUSE: begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                        S_RUN: begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    if (w_dirp) begin
                        r_dir <= ~r_dir;
                    end
                    if (w_stop) begin
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_dirp && (r_state == S_DONE)) begin
                        r_state <= S_PAUSE;
                        r_done  <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.tick    = r_tick;
    assign bus.dir     = r_dir;
    assign bus.clr     = r_clr;
    assign bus.running = r_running;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: table-driven event sequence plus hand-timed
// sequences for latency, glitch, fast switching, one-shot, simultaneous events and reset.
module tb_count_ctrl;

    localparam int unsigned TD = 10;
    localparam int unsigned DB = 4;

    logic clk;
    logic rst;
    count_ctrl_if bus ();

    count_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tick_cnt = 0;
    int clr_cnt  = 0;
    int overlap  = 0;

    always @(negedge clk) begin
        if (bus.tick === 1'b1) tick_cnt++;
        if (bus.clr === 1'b1) clr_cnt++;
        if (bus.tick === 1'b1 && bus.clr === 1'b1) overlap++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input int idx);
        @(negedge clk);
        bus.btn_n[idx] = 1'b0;
        repeat (DB + 6) @(negedge clk);
        bus.btn_n[idx] = 1'b1;
        repeat (DB + 6) @(negedge clk);
    endtask

    task automatic wait_tick(output int e);
        e = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.tick === 1'b1) begin
                e = cyc;
                break;
            end
        end
        if (e < 0) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout actual=none expected=tick within 30 cycles");
        end
    endtask

    typedef struct {
        int   btn;
        logic exp_run;
        logic exp_done;
        logic exp_dir;
        int   exp_clr;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_edge, done_edge, fall_edge, ntk, run_max, c0, t0, a, b, c, t1, tt, w, w2;
        int tk [3];

        bus.btn_n  = 3'b111;
        bus.sw     = 3'b000;
        bus.at_max = 1'b0;
        bus.at_min = 1'b0;
        rst        = 1'b1;

        // Reset state
        do_reset();
        chk("rst_tick",    int'(bus.tick),    0);
        chk("rst_dir",     int'(bus.dir),     0);
        chk("rst_clr",     int'(bus.clr),     0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_done",    int'(bus.done),    0);

        // Table-driven event sequence with the prescaler frozen
        vecs[0] = '{0, 1'b1, 1'b0, 1'b0, 0};
        vecs[1] = '{2, 1'b1, 1'b0, 1'b1, 0};
        vecs[2] = '{0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{2, 1'b0, 1'b0, 1'b0, 0};
        vecs[4] = '{0, 1'b1, 1'b0, 1'b0, 0};
        vecs[5] = '{1, 1'b0, 1'b0, 1'b0, 1};
        vecs[6] = '{2, 1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{1, 1'b0, 1'b0, 1'b1, 1};
        vecs[8] = '{0, 1'b1, 1'b0, 1'b1, 0};
        bus.sw = 3'b100;
        for (int i = 0; i < 9; i++) begin
            c0 = clr_cnt;
            t0 = tick_cnt;
            press(vecs[i].btn);
            chk($sformatf("vec%0d_running", i), int'(bus.running), int'(vecs[i].exp_run));
            chk($sformatf("vec%0d_done", i),    int'(bus.done),    int'(vecs[i].exp_done));
            chk($sformatf("vec%0d_dir", i),     int'(bus.dir),     int'(vecs[i].exp_dir));
            chk($sformatf("vec%0d_clr", i),     clr_cnt - c0,      vecs[i].exp_clr);
            chk($sformatf("vec%0d_ticks", i),   tick_cnt - t0,     0);
        end

        // Glitch shorter than the debounce period
        do_reset();
        bus.sw = 3'b000;
        @(negedge clk);
        bus.btn_n[0] = 1'b0;
        repeat (3) step();
        bus.btn_n[0] = 1'b1;
        run_max = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.running === 1'b1) run_max = 1;
        end
        chk("glitch_running", run_max, 0);

        // Start latency and tick cadence
        do_reset();
        @(negedge clk);
        bus.btn_n[0] = 1'b0;
        cyc = 0;
        run_edge = -1;
        ntk = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cyc == 20) bus.btn_n[0] = 1'b1;
            if (bus.running === 1'b1 && run_edge < 0) run_edge = cyc;
            if (bus.tick === 1'b1 && ntk < 3) begin
                tk[ntk] = cyc;
                ntk++;
            end
        end
        chk("start_run_edge", run_edge, 8);
        chk("tick0_edge", tk[0], 18);
        chk("tick1_edge", tk[1], 28);
        chk("tick2_edge", tk[2], 38);

        // Fast mode period
        bus.sw[0] = 1'b1;
        wait_tick(a);
        wait_tick(b);
        wait_tick(c);
        chk("fast_period_a", b - a, 5);
        chk("fast_period_b", c - b, 5);

        // Back to normal, then switch to fast mid-count at prescaler 7
        bus.sw[0] = 1'b0;
        wait_tick(a);
        wait_tick(t1);
        wait_tick(tt);
        chk("normal_period", tt - t1, 10);
        repeat (5) step();
        bus.sw[0] = 1'b1;
        wait_tick(w);
        chk("fast_switch_within4", int'((w > tt + 7) && (w <= tt + 11)), 1);
        wait_tick(w2);
        chk("fast_switch_period", w2 - w, 5);

        // One-shot stop at terminal value
        do_reset();
        bus.sw     = 3'b010;
        bus.at_max = 1'b1;
        repeat (3) step();
        @(negedge clk);
        bus.btn_n[0] = 1'b0;
        cyc = 0;
        run_edge = -1;
        done_edge = -1;
        fall_edge = -1;
        t0 = tick_cnt;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cyc == 12) bus.btn_n[0] = 1'b1;
            if (bus.running === 1'b1 && run_edge < 0) run_edge = cyc;
            if (bus.running === 1'b0 && run_edge >= 0 && fall_edge < 0) fall_edge = cyc;
            if (bus.done === 1'b1 && done_edge < 0) done_edge = cyc;
        end
        chk("oneshot_run_edge", run_edge, 8);
        chk("oneshot_done_edge", done_edge, 18);
        chk("oneshot_fall_edge", fall_edge, 18);
        chk("oneshot_no_tick", tick_cnt - t0, 0);
        press(0);
        chk("done_start_done", int'(bus.done), 1);
        chk("done_start_running", int'(bus.running), 0);
        press(2);
        chk("done_dir_dir", int'(bus.dir), 1);
        chk("done_dir_done", int'(bus.done), 0);
        chk("done_dir_running", int'(bus.running), 0);
        press(0);
        chk("pause_resume_running", int'(bus.running), 1);
        wait_tick(a);
        chk("resume_tick_seen", int'(a > 0), 1);

        // Clear and start debounced together while paused
        do_reset();
        bus.sw     = 3'b100;
        bus.at_max = 1'b0;
        press(2);
        press(0);
        press(0);
        chk("pause_running", int'(bus.running), 0);
        c0 = clr_cnt;
        @(negedge clk);
        bus.btn_n[0] = 1'b0;
        bus.btn_n[1] = 1'b0;
        run_max = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 10) bus.btn_n = 3'b111;
            if (bus.running === 1'b1) run_max = 1;
        end
        chk("clr_start_clr_pulses", clr_cnt - c0, 1);
        chk("clr_start_running", run_max, 0);
        chk("clr_start_dir", int'(bus.dir), 1);
        chk("clr_start_done", int'(bus.done), 0);

        // Asynchronous reset while running down with hold
        press(0);
        chk("pre_rst_running", int'(bus.running), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs",
            int'({bus.tick, bus.dir, bus.clr, bus.running, bus.done}), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.sw = 3'b000;
        t0 = tick_cnt;
        repeat (40) step();
        chk("post_rst_no_tick", tick_cnt - t0, 0);
        chk("post_rst_running", int'(bus.running), 0);

        chk("tick_clr_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
